seq_chunk_adder: RTL and testbench

//  Parametrised multi-cycle add/subtract unit. Splits WIDTH-bit operands into CHUNK-bit slices.

---
 rtl/seq_chunk_adder_if.sv | 27 ++
 rtl/seq_chunk_adder.sv | 101 ++++++++++
 tb/tb_seq_chunk_adder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seq_chunk_adder_if.sv
// Handshake and data bundle for seq_chunk_adder: operand side (in_*) and result side (out_*).
// The slave modport is the adder; the master modport is the producer/consumer around it.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 25
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock through a registered carry.
//   state  | meaning
//   IDLE   | waiting for operands, in_ready=1
//   RUN    | adding slice idx, sum built up slice by slice
//   DONE   | result held until out_ready
module seq_chunk_adder #(
    parameter int WIDTH = 25,
    parameter int CHUNK = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    seq_chunk_adder_if.slave   bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LAST   = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int WW     = WIDTH + CHUNK;
    localparam int CW     = CHUNK + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CHUNK-1:0] MASK = '1;

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;
    logic             ovf_r;

    int               sh;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice;
    logic [WIDTH-1:0] sum_next;
    logic             is_last;
    logic             last_cout;
    logic             last_cin;

    // Bits above WIDTH shift in as zero, so the partial last slice adds only its low LAST bits.
    always_comb begin
        sh        = int'(idx) * CHUNK;
        a_sl      = CHUNK'(a_r >> sh);
        b_sl      = CHUNK'(b_r >> sh);
        slice     = {1'b0, a_sl} + {1'b0, b_sl} + CW'(carry);
        sum_next  = WIDTH'((WW'(sum_r) & ~(WW'(MASK) << sh)) | (WW'(slice[CHUNK-1:0]) << sh));
        is_last   = (idx == IDXW'(NCHUNK - 1));
        last_cout = slice[LAST];
        last_cin  = a_sl[LAST-1] ^ b_sl[LAST-1] ^ slice[LAST-1];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.c_in ^ bus.sub;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_r <= sum_next;
                    carry <= slice[CHUNK];
                    if (is_last) begin
                        c_out_r <= last_cout;
                        ovf_r   <= last_cout ^ last_cin;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Drives three adder configurations (25/9, 8/8, 8/1) with directed and random operands
// and compares results and latency against a plain-arithmetic reference.
module tb_seq_chunk_adder;
    localparam int W0 = 25, C0 = 9, N0 = 3;
    localparam int W1 = 8,  C1 = 8, N1 = 1;
    localparam int W2 = 8,  C2 = 1, N2 = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(W0)) if0 ();
    seq_chunk_adder_if #(.WIDTH(W1)) if1 ();
    seq_chunk_adder_if #(.WIDTH(W2)) if2 ();

    seq_chunk_adder #(.WIDTH(W0), .CHUNK(C0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    seq_chunk_adder #(.WIDTH(W1), .CHUNK(C1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    seq_chunk_adder #(.WIDTH(W2), .CHUNK(C2)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result packed as {ovf, c_out} at bits 33:32, sum in the low bits.
    function automatic logic [63:0] model(input int w, input logic [24:0] a_in, input logic [24:0] b_in,
                                          input logic cin, input logic sub_op);
        longint unsigned m, a, b, ru;
        longint          sa, sbs, rs, lim;
        logic            co, ov;
        m   = (64'd1 << w) - 64'd1;
        a   = 64'(a_in) & m;
        b   = 64'(b_in) & m;
        lim = longint'(64'd1 << (w - 1));
        sa  = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
        sbs = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
        if (!sub_op) begin
            ru = a + b + 64'(cin);
            co = (ru >> w) != 0;
            rs = sa + sbs + longint'(cin);
        end else begin
            co = (a >= b + 64'(cin));
            ru = a - b - 64'(cin);
            rs = sa - sbs - longint'(cin);
        end
        ov = (rs >= lim) || (rs < -lim);
        return (ru & m) | (64'(co) << 32) | (64'(ov) << 33);
    endfunction

    task automatic set_valid(input logic v);
        if0.in_valid = v;
        if1.in_valid = v;
        if2.in_valid = v;
    endtask

    task automatic run_op(input logic [24:0] a, input logic [24:0] b, input logic cin, input logic sub_op);
        logic [63:0] e0, e1, e2;
        bit d0, d1, d2;
        int cyc;
        e0 = model(W0, a, b, cin, sub_op);
        e1 = model(W1, a, b, cin, sub_op);
        e2 = model(W2, a, b, cin, sub_op);
        if0.a = a;      if0.b = b;      if0.c_in = cin; if0.sub = sub_op;
        if1.a = a[7:0]; if1.b = b[7:0]; if1.c_in = cin; if1.sub = sub_op;
        if2.a = a[7:0]; if2.b = b[7:0]; if2.c_in = cin; if2.sub = sub_op;
        chk("in_ready_idle", {61'd0, if0.in_ready, if1.in_ready, if2.in_ready}, 64'd7);
        set_valid(1'b1);
        @(posedge clk); #1;
        set_valid(1'b0);
        // Scramble operands after accept; the result must not follow them.
        if0.a = 25'($urandom); if0.b = 25'($urandom); if0.c_in = ~cin; if0.sub = ~sub_op;
        if1.a = 8'($urandom);  if1.b = 8'($urandom);  if1.c_in = ~cin; if1.sub = ~sub_op;
        if2.a = 8'($urandom);  if2.b = 8'($urandom);  if2.c_in = ~cin; if2.sub = ~sub_op;
        chk("in_ready_busy0", 64'(if0.in_ready), 64'd0);
        d0 = 0; d1 = 0; d2 = 0; cyc = 0;
        while (!(d0 && d1 && d2) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!d0 && if0.out_valid) begin
                d0 = 1;
                chk("lat0", 64'(cyc), 64'(N0));
                chk("sum0", 64'(if0.sum), e0 & 64'h1FFFFFF);
                chk("cout0", 64'(if0.c_out), 64'(e0[32]));
                chk("ovf0", 64'(if0.ovf), 64'(e0[33]));
            end
            if (!d1 && if1.out_valid) begin
                d1 = 1;
                chk("lat1", 64'(cyc), 64'(N1));
                chk("sum1", 64'(if1.sum), e1 & 64'hFF);
                chk("cout1", 64'(if1.c_out), 64'(e1[32]));
                chk("ovf1", 64'(if1.ovf), 64'(e1[33]));
            end
            if (!d2 && if2.out_valid) begin
                d2 = 1;
                chk("lat2", 64'(cyc), 64'(N2));
                chk("sum2", 64'(if2.sum), e2 & 64'hFF);
                chk("cout2", 64'(if2.c_out), 64'(e2[32]));
                chk("ovf2", 64'(if2.ovf), 64'(e2[33]));
            end
        end
        chk("done_in_budget", {61'd0, d0, d1, d2}, 64'd7);
        @(posedge clk); #1;
    endtask

    logic [24:0] va [6] = '{25'h1FFFFFF, 25'd5, 25'h0FFFFFF, 25'h1000000, 25'h00001FF, 25'h003FFFF};
    logic [24:0] vb [6] = '{25'd1, 25'd7, 25'd1, 25'd1, 25'd1, 25'd1};
    logic        vs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [63:0] e;
        set_valid(1'b0);
        if0.out_ready = 1'b1; if1.out_ready = 1'b1; if2.out_ready = 1'b1;
        if0.a = '0; if0.b = '0; if0.c_in = 1'b0; if0.sub = 1'b0;
        if1.a = '0; if1.b = '0; if1.c_in = 1'b0; if1.sub = 1'b0;
        if2.a = '0; if2.b = '0; if2.c_in = 1'b0; if2.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {61'd0, if0.in_ready, if1.in_ready, if2.in_ready}, 64'd7);
        chk("rst_out_valid", {61'd0, if0.out_valid, if1.out_valid, if2.out_valid}, 64'd0);
        chk("rst_sum0", 64'(if0.sum), 64'd0);
        chk("rst_flags0", {62'd0, if0.c_out, if0.ovf}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Spec vectors on all three configurations
        for (int i = 0; i < 6; i++) run_op(va[i], vb[i], 1'b0, vs[i]);
        // Carry/borrow-in corners
        run_op(25'h1FFFFFF, 25'h1FFFFFF, 1'b1, 1'b0);
        run_op(25'd0, 25'd0, 1'b1, 1'b1);

        for (int i = 0; i < 25; i++)
            run_op(25'($urandom), 25'($urandom), 1'($urandom), 1'($urandom));

        // Backpressure on the 25/9 unit
        e = model(W0, 25'h0ABCDEF, 25'h1234567, 1'b1, 1'b0);
        if0.a = 25'h0ABCDEF; if0.b = 25'h1234567; if0.c_in = 1'b1; if0.sub = 1'b0;
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.a = 25'h0000001; if0.b = 25'h0000001; if0.c_in = 1'b0;
        repeat (N0) @(posedge clk);
        #1;
        chk("bp_valid_rise", 64'(if0.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_hold", 64'(if0.out_valid), 64'd1);
            chk("bp_in_ready", 64'(if0.in_ready), 64'd0);
            chk("bp_sum_hold", 64'(if0.sum), e & 64'h1FFFFFF);
            chk("bp_cout_hold", 64'(if0.c_out), 64'(e[32]));
        end
        if0.in_valid = 1'b0;
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 64'(if0.in_ready), 64'd1);
        chk("bp_release_valid", 64'(if0.out_valid), 64'd0);
        chk("idle_sum_hold", 64'(if0.sum), e & 64'h1FFFFFF);

        // Reset on the second RUN edge
        if0.a = 25'h1FFFFFF; if0.b = 25'h1FFFFFF; if0.c_in = 1'b1; if0.sub = 1'b0;
        if1.a = 8'hFF; if1.b = 8'hFF; if2.a = 8'hFF; if2.b = 8'hFF;
        set_valid(1'b1);
        @(posedge clk); #1;
        set_valid(1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rrun_in_ready", {61'd0, if0.in_ready, if1.in_ready, if2.in_ready}, 64'd7);
        chk("rrun_out_valid", {61'd0, if0.out_valid, if1.out_valid, if2.out_valid}, 64'd0);
        chk("rrun_sum0", 64'(if0.sum), 64'd0);
        chk("rrun_sum2", 64'(if2.sum), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(25'h1234567, 25'h0FEDCBA, 1'b0, 1'b1);
        run_op(25'h00001FF, 25'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
